// File: rtl/dm_pkg.sv
// ----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory arbiter slice:
//   - state_e   : FSM state encoding for dm_arbiter (IDLE / ISSUE / WAIT)
//   - PORT_CPU  : index of the processor-side data port (port 0)
//   - PORT_DBG  : index of the display/debug scan port (port 1)
//   - DEF_ADDR_W / DEF_DATA_W : default RAM geometry (64 x 32)
//   - STAT_W    : width of the optional statistics counters
// ----------------------------------------------------------------------------
package dm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam int PORT_CPU   = 0;
    localparam int PORT_DBG   = 1;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 32;

    localparam int STAT_W     = 16;

endpackage : dm_pkg

// File: rtl/dm_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin winner select with its priority pointer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> port 0)
//   req0, req1 : requests currently presented
//   advance    : a grant is being taken this cycle; pointer moves past winner
//   win        : combinational winner index (PORT_CPU / PORT_DBG)
// ----------------------------------------------------------------------------
module rr_arb2
    import dm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic win
);

    logic ptr_q, ptr_d;

    // The pointer only matters on a tie; a lone request always wins.
    always_comb begin
        if (req0 && req1) begin
            win = ptr_q;
        end else if (req1) begin
            win = 1'(PORT_DBG);
        end else begin
            win = 1'(PORT_CPU);
        end
    end

    // After a grant, priority passes to the port that did not win.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = ~win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'(PORT_CPU);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arb2

// File: rtl/dm_arbiter.sv
// ----------------------------------------------------------------------------
// dm_arbiter
// Round-robin arbiter/sequencer sharing one single-port synchronous-read RAM
// between the processor data port (port 0) and the debug scan port (port 1).
// Accesses are serialised: IDLE samples requests, ISSUE strobes the RAM for
// one cycle with the winner's grant, WAIT (reads only) counts RD_LAT cycles
// and captures read data; rvalid pulses in the following cycle.
//
// Parameters: ADDR_W (word address width), DATA_W (data width),
//             RD_LAT (RAM read latency, legal 1..3).
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   req*/we*/addr*/wdata*    : requester side, held until gnt is seen
//   gnt*                     : one-cycle grant pulse (in the ISSUE cycle)
//   rvalid*/rdata*           : read-data valid pulse / held read data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : RAM pins
//   stat_gnt0/stat_gnt1/stat_conflict : saturating 16-bit counters, present
//                              only when DM_ARB_STATS_EN is defined
// ----------------------------------------------------------------------------
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_gnt0,
    output logic [15:0]       stat_gnt1,
    output logic [15:0]       stat_conflict
`endif
);

    // WAIT lasts RD_LAT cycles; the counter reaching zero marks the last one.
    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;

    logic              any_req;
    logic              accept;
    logic              capture;
    logic              arb_win;

    assign any_req = req0 || req1;
    assign accept  = (state_q == ST_IDLE) && any_req;
    assign capture = (state_q == ST_WAIT) && (cnt_q == 2'd0);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .advance (accept),
        .win     (arb_win)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        mem_en = 1'b0;
        mem_we = 1'b0;
        if (state_q == ST_ISSUE) begin
            mem_en = 1'b1;
            mem_we = we_q;
            gnt0   = (win_q == 1'(PORT_CPU));
            gnt1   = (win_q == 1'(PORT_DBG));
        end
    end

    // Address/data are driven straight from the request latch, so they hold
    // their last value whenever the RAM is not strobed.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;

    // Request latch: loaded only when a winner is taken in IDLE.
    always_comb begin
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            win_d = arb_win;
            if (arb_win == 1'(PORT_DBG)) begin
                we_d    = we1;
                addr_d  = addr1;
                wdata_d = wdata1;
            end else begin
                we_d    = we0;
                addr_d  = addr0;
                wdata_d = wdata0;
            end
        end
    end

    // Read return: only the winning port's data register ever moves.
    always_comb begin
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        if (capture) begin
            if (win_q == 1'(PORT_DBG)) begin
                rdata1_d  = mem_rdata;
                rvalid1_d = 1'b1;
            end else begin
                rdata0_d  = mem_rdata;
                rvalid0_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q     <= 1'(PORT_CPU);
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            win_q     <= win_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

`ifdef DM_ARB_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [STAT_W-1:0] stat_gnt0_q, stat_gnt0_d;
    logic [STAT_W-1:0] stat_gnt1_q, stat_gnt1_d;
    logic [STAT_W-1:0] stat_conflict_q, stat_conflict_d;

    // Counted at the IDLE decision point, where the winner is chosen.
    always_comb begin
        stat_gnt0_d     = stat_gnt0_q;
        stat_gnt1_d     = stat_gnt1_q;
        stat_conflict_d = stat_conflict_q;
        if (accept) begin
            if (arb_win == 1'(PORT_DBG)) begin
                stat_gnt1_d = sat_inc(stat_gnt1_q);
            end else begin
                stat_gnt0_d = sat_inc(stat_gnt0_q);
            end
            if (req0 && req1) begin
                stat_conflict_d = sat_inc(stat_conflict_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_gnt0_q     <= '0;
            stat_gnt1_q     <= '0;
            stat_conflict_q <= '0;
        end else begin
            stat_gnt0_q     <= stat_gnt0_d;
            stat_gnt1_q     <= stat_gnt1_d;
            stat_conflict_q <= stat_conflict_d;
        end
    end

    assign stat_gnt0     = stat_gnt0_q;
    assign stat_gnt1     = stat_gnt1_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule : dm_arbiter

// File: tb/tb_dm_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dm_arbiter
// Self-checking bench for dm_arbiter. Instance "dut" uses RD_LAT=1, instance
// "dut3" uses RD_LAT=3; each drives its own behavioural RAM. Directed tasks
// cover the listed scenarios; test_random runs protocol-following random
// requesters against a transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_dm_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // RD_LAT = 1 instance
    logic        req0, req1, we0, we1;
    logic [5:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_en, mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    // RD_LAT = 3 instance
    logic        b_req0, b_req1, b_we0, b_we1;
    logic [5:0]  b_addr0, b_addr1;
    logic [31:0] b_wdata0, b_wdata1;
    logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1;
    logic [31:0] b_rdata0, b_rdata1;
    logic        b_mem_en, b_mem_we;
    logic [5:0]  b_mem_addr;
    logic [31:0] b_mem_wdata, b_mem_rdata;

    int checks = 0;
    int errors = 0;

    bit [31:0] ref_mem [64];

    dm_arbiter #(.ADDR_W(6), .DATA_W(32), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dm_arbiter #(.ADDR_W(6), .DATA_W(32), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
        .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
        .rdata0(b_rdata0), .rdata1(b_rdata1),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // RAM models: data is only meaningful in the cycle the read lands,
    // otherwise a poison pattern is presented.
    bit   [31:0] ram_a [64];
    logic [31:0] pd_a;
    always @(posedge clk) begin
        if (mem_en && mem_we) ram_a[mem_addr] <= mem_wdata;
        pd_a <= (mem_en && !mem_we) ? ram_a[mem_addr] : 32'hDEAD_BEEF;
    end
    assign mem_rdata = pd_a;

    bit   [31:0] ram_b [64];
    logic [31:0] pb0, pb1, pb2;
    always @(posedge clk) begin
        if (b_mem_en && b_mem_we) ram_b[b_mem_addr] <= b_mem_wdata;
        pb0 <= (b_mem_en && !b_mem_we) ? ram_b[b_mem_addr] : 32'hDEAD_BEEF;
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign b_mem_rdata = pb2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic idle_inputs;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0; b_addr0 = 0; b_addr1 = 0;
        b_wdata0 = 0; b_wdata1 = 0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we});
        end
        checks++;
        if (mem_addr !== 6'd0 || mem_wdata !== 32'd0 || rdata0 !== 32'd0 || rdata1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata0=%h rdata1=%h expected all zero",
                     mem_addr, mem_wdata, rdata0, rdata1);
        end
        checks++;
        if ({b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_en, b_mem_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl_lat3: got %b expected 000000",
                     {b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_en, b_mem_we});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, mem_en} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected 000", {gnt0, gnt1, mem_en});
        end
    endtask

    task automatic test_write_read;
        req0 = 1; we0 = 1; addr0 = 6'd5; wdata0 = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, mem_en, mem_we} !== 4'b1011) begin
            errors++;
            $display("FAIL wr_issue: got gnt0,gnt1,en,we=%b expected 1011", {gnt0, gnt1, mem_en, mem_we});
        end
        checks++;
        if (mem_addr !== 6'd5 || mem_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL wr_payload: got addr=%h wdata=%h expected 05 12345678", mem_addr, mem_wdata);
        end
        req0 = 0; we0 = 0;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, mem_en, mem_we} !== 4'b0000) begin
            errors++;
            $display("FAIL wr_back_idle: got %b expected 0000", {gnt0, gnt1, mem_en, mem_we});
        end
        req1 = 1; we1 = 0; addr1 = 6'd5;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, mem_en, mem_we} !== 4'b0110 || mem_addr !== 6'd5) begin
            errors++;
            $display("FAIL rd_issue: got %b addr=%h expected 0110 addr=05", {gnt0, gnt1, mem_en, mem_we}, mem_addr);
        end
        req1 = 0;
        @(negedge clk);
        checks++;
        if ({rvalid0, rvalid1, mem_en} !== 3'b000) begin
            errors++;
            $display("FAIL rd_wait: got rv0,rv1,en=%b expected 000", {rvalid0, rvalid1, mem_en});
        end
        @(negedge clk);
        checks++;
        if ({rvalid0, rvalid1} !== 2'b01 || rdata1 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd_return: got rv=%b rdata1=%h expected 01 12345678", {rvalid0, rvalid1}, rdata1);
        end
        checks++;
        if (rdata0 !== 32'd0) begin
            errors++;
            $display("FAIL rdata0_untouched: got %h expected 00000000", rdata0);
        end
        @(negedge clk);
        checks++;
        if (rvalid1 !== 1'b0 || rdata1 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd_hold: got rv1=%b rdata1=%h expected 0 12345678", rvalid1, rdata1);
        end
    endtask

    task automatic test_alternate;
        int order[$];
        int gcyc[$];
        int cyc;
        cyc = 0;
        req0 = 1; we0 = 0; addr0 = 6'd1;
        req1 = 1; we1 = 0; addr1 = 6'd2;
        while (order.size() < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (gnt0) begin order.push_back(0); gcyc.push_back(cyc); end
            if (gnt1) begin order.push_back(1); gcyc.push_back(cyc); end
            if (order.size() >= 4) begin req0 = 0; req1 = 0; end
        end
        req0 = 0; req1 = 0;
        checks++;
        if (order.size() != 4) begin
            errors++;
            $display("FAIL alt_count: got %0d grants expected 4", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            checks++;
            if (order[i] != (i % 2) || gcyc[i] != 1 + 3 * i) begin
                errors++;
                $display("FAIL alt_grant%0d: got port %0d at cycle %0d expected port %0d at cycle %0d",
                         i, order[i], gcyc[i], i % 2, 1 + 3 * i);
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rd_lat3;
        b_req0 = 1; b_we0 = 1; b_addr0 = 6'd9; b_wdata0 = 32'h8765_4321;
        @(negedge clk);
        checks++;
        if ({b_gnt0, b_mem_en, b_mem_we} !== 3'b111) begin
            errors++;
            $display("FAIL lat3_wr_issue: got %b expected 111", {b_gnt0, b_mem_en, b_mem_we});
        end
        b_req0 = 0;
        @(negedge clk);
        b_req0 = 1; b_we0 = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if ({b_gnt0, b_mem_en, b_mem_we} !== 3'b110) begin
                    errors++;
                    $display("FAIL lat3_rd_issue: got %b expected 110", {b_gnt0, b_mem_en, b_mem_we});
                end
                b_req0 = 0;
            end
            checks++;
            if (b_rvalid0 !== (c == 5)) begin
                errors++;
                $display("FAIL lat3_rvalid_c%0d: got %b expected %b", c, b_rvalid0, (c == 5));
            end
            if (c == 5) begin
                checks++;
                if (b_rdata0 !== 32'h8765_4321) begin
                    errors++;
                    $display("FAIL lat3_rdata: got %h expected 87654321", b_rdata0);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        req0 = 1; we0 = 0; addr0 = 6'd5;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_gnt: got %b expected 1", gnt0);
        end
        req0 = 0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we} !== 6'b0 || mem_addr !== 6'd0 ||
            mem_wdata !== 32'd0 || rdata0 !== 32'd0 || rdata1 !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_async: got ctrl=%b addr=%h wdata=%h rd0=%h rd1=%h expected all zero",
                     {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we}, mem_addr, mem_wdata, rdata0, rdata1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({gnt0, gnt1, rvalid0, rvalid1, mem_en} !== 5'b0) begin
                errors++;
                $display("FAIL rstmid_abandon_c%0d: got %b expected 00000", c, {gnt0, gnt1, rvalid0, rvalid1, mem_en});
            end
        end
        req0 = 1; we0 = 0; addr0 = 6'd1;
        req1 = 1; we1 = 0; addr1 = 6'd2;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_first_tie: got gnt0,gnt1=%b expected 10", {gnt0, gnt1});
        end
        req0 = 0; req1 = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_lone_repeat;
        req1 = 1; we1 = 1; addr1 = 6'd3; wdata1 = 32'hA5A5_0003;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            errors++;
            $display("FAIL lone_first: got %b expected 01", {gnt0, gnt1});
        end
        addr1 = 6'd4; wdata1 = 32'hA5A5_0004;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
            errors++;
            $display("FAIL lone_gap: got %b expected 00", {gnt0, gnt1});
        end
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b01 || mem_addr !== 6'd4 || mem_wdata !== 32'hA5A5_0004) begin
            errors++;
            $display("FAIL lone_again: got gnt=%b addr=%h wdata=%h expected 01 04 a5a50004",
                     {gnt0, gnt1}, mem_addr, mem_wdata);
        end
        req1 = 0; we1 = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random;
        bit        p0, p1, w0, w1;
        bit [5:0]  a0, a1;
        bit [31:0] d0, d1;
        int        free_cyc, g_cyc, g_port, rv_cyc, rv_port, win, ngrants;
        bit        g_we, ptr_m, eg0, eg1, een, ev0, ev1;
        bit [5:0]  g_addr;
        bit [31:0] g_wdata, rv_data;
        bit [31:0] exp_rd [2];

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p0 = 0; p1 = 0; w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        free_cyc = 0; g_cyc = -1; g_port = 0; rv_cyc = -1; rv_port = 0; ngrants = 0;
        g_we = 0; g_addr = 0; g_wdata = 0; rv_data = 0; ptr_m = 0;
        exp_rd[0] = 0; exp_rd[1] = 0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            eg0 = (cyc == g_cyc) && (g_port == 0);
            eg1 = (cyc == g_cyc) && (g_port == 1);
            een = (cyc == g_cyc);
            checks++;
            if ({gnt0, gnt1} !== {eg0, eg1}) begin
                errors++;
                $display("FAIL rnd_gnt@%0d: got %b expected %b", cyc, {gnt0, gnt1}, {eg0, eg1});
            end
            checks++;
            if ({mem_en, mem_we} !== {een, een && g_we}) begin
                errors++;
                $display("FAIL rnd_strobe@%0d: got %b expected %b", cyc, {mem_en, mem_we}, {een, een && g_we});
            end
            if (een) begin
                ngrants++;
                checks++;
                if (mem_addr !== g_addr || (g_we && mem_wdata !== g_wdata)) begin
                    errors++;
                    $display("FAIL rnd_payload@%0d: got addr=%h wdata=%h expected addr=%h wdata=%h",
                             cyc, mem_addr, mem_wdata, g_addr, g_wdata);
                end
            end
            if (cyc == rv_cyc) exp_rd[rv_port] = rv_data;
            ev0 = (cyc == rv_cyc) && (rv_port == 0);
            ev1 = (cyc == rv_cyc) && (rv_port == 1);
            checks++;
            if ({rvalid0, rvalid1} !== {ev0, ev1}) begin
                errors++;
                $display("FAIL rnd_rvalid@%0d: got %b expected %b", cyc, {rvalid0, rvalid1}, {ev0, ev1});
            end
            checks++;
            if (rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin
                errors++;
                $display("FAIL rnd_rdata@%0d: got %h %h expected %h %h", cyc, rdata0, rdata1, exp_rd[0], exp_rd[1]);
            end

            // Requesters: a grant retires the held request; new ones appear at random.
            if (eg0) p0 = 0;
            if (eg1) p1 = 0;
            if (!p0 && $urandom_range(0, 1) == 1) begin
                p0 = 1; w0 = 1'($urandom_range(0, 1)); a0 = 6'(32 + $urandom_range(0, 7)); d0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 1) == 1) begin
                p1 = 1; w1 = 1'($urandom_range(0, 1)); a1 = 6'(32 + $urandom_range(0, 7)); d1 = $urandom;
            end
            req0 = p0; we0 = w0; addr0 = a0; wdata0 = d0;
            req1 = p1; we1 = w1; addr1 = a1; wdata1 = d1;

            // Reference: one access at a time; a write occupies 2 cycles,
            // a read 2+RD_LAT cycles; ties go to the port not served last.
            if (cyc >= free_cyc && (p0 || p1)) begin
                if (p0 && p1) win = int'(ptr_m);
                else          win = p1 ? 1 : 0;
                ptr_m   = (win == 0);
                g_cyc   = cyc + 1;
                g_port  = win;
                g_we    = (win == 1) ? w1 : w0;
                g_addr  = (win == 1) ? a1 : a0;
                g_wdata = (win == 1) ? d1 : d0;
                if (g_we) begin
                    ref_mem[g_addr] = g_wdata;
                    free_cyc = cyc + 2;
                end else begin
                    rv_cyc   = cyc + 3;
                    rv_port  = win;
                    rv_data  = ref_mem[g_addr];
                    free_cyc = cyc + 3;
                end
            end
        end
        req0 = 0; req1 = 0;
        repeat (5) @(negedge clk);
        checks++;
        if (ngrants < 50) begin
            errors++;
            $display("FAIL rnd_activity: got %0d grants expected at least 50", ngrants);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_write_read();
        test_alternate();
        test_rd_lat3();
        test_reset_mid();
        test_lone_repeat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dm_arbiter
